path_read_buffer: RTL and testbench
===================================

PATH_READ_BUFFER -- requirements
Module: path_read_buffer

Interface
REQ-001 SHALL have parameter BEDWidth, default 512: width of one DRAM read beat.
REQ-002 SHALL have parameter Depth, default 8 (power of two): buffer capacity in beats.
REQ-003 SHALL have parameter PathBeats, default 6: beats in one full ORAM path read.
REQ-004 SHALL have port Clock  input  1: single clock; all logic rising-edge.
REQ-005 SHALL have port Reset  input  1: synchronous, active-high reset.
REQ-006 SHALL have port DRAMReadData  input  BEDWidth: raw DRAM read beat.
REQ-007 SHALL have port DRAMReadDataValid  input  1: beat present; DRAM cannot be stalled.
REQ-008 SHALL have port DRAMReadDataReady  output  1: space available this cycle (advisory; feeds the error monitor).
REQ-009 SHALL have port OutData  output  BEDWidth: head beat to the AES/backend consumer.
REQ-010 SHALL have port OutValid  output  1: OutData valid.
REQ-011 SHALL have port OutReady  input  1: consumer accepts head beat.
REQ-012 SHALL have port Count  output  log2(Depth+1): beats currently held.
REQ-013 SHALL have port PathDone  output  1: one-cycle pulse on pop of the last beat of a path.
REQ-014 SHALL have port Overflow  output  1: sticky flag, beat lost.

Function
REQ-015 SHALL push when DRAMReadDataValid && DRAMReadDataReady; pop when OutValid && OutReady.
REQ-016 SHALL drive DRAMReadDataReady = (Count < Depth) || (OutValid && OutReady), combinationally.
REQ-017 SHALL, on a push into an empty buffer, assert OutValid on the next cycle with that beat (1-cycle latency); no same-cycle bypass.
REQ-018 SHALL hold OutData stable while OutValid && !OutReady.
REQ-019 SHALL deliver beats in strict arrival order; read/write pointers wrap modulo Depth.
REQ-020 SHALL, on simultaneous push and pop, leave Count unchanged, including at Count == Depth.
REQ-021 SHALL drop the beat and not corrupt contents when DRAMReadDataValid && !DRAMReadDataReady.
REQ-022 SHALL keep a pop counter 0..PathBeats-1: increment per pop, wrap to 0 after PathBeats-1, pulse PathDone on that wrapping pop.
REQ-023 SHALL never let Count exceed Depth nor underflow below 0.

Reset
REQ-024 SHALL, when Reset is high at a clock edge, clear pointers, Count = 0, pop counter = 0, Overflow = 0, OutValid = 0, PathDone = 0; OutData don't-care.
REQ-025 SHALL discard buffered beats on reset mid-path; input beats in the Reset cycle are ignored.
REQ-026 SHALL not require memory array contents to be reset.

Configuration
REQ-027 SHALL support macro PBF_OVERFLOW_CHECK_EN.
REQ-028 SHALL, with PBF_OVERFLOW_CHECK_EN defined, set Overflow on the cycle after any dropped beat, hold it until Reset, and under SIMULATION print an error and stop.
REQ-029 SHALL, without PBF_OVERFLOW_CHECK_EN, tie Overflow to 0; drop behaviour per REQ-021 is unchanged.

Structure
REQ-030 SHALL take Depth and PathBeats from the shared ORAM headers (PathORAM.vh/BucketLocal.vh, derived from ORAML, ORAMZ, BEDWidth); no local redefinition.
REQ-031 SHALL isolate storage in one sub-module, PathBufferRAM (Depth x BEDWidth, 1 write port, 1 registered read port); control, pointers, and counters stay in path_read_buffer.

Verification
REQ-032 SHALL test: reset, then a single push of 0xA5.., OutReady = 1 -> OutValid high the next cycle with 0xA5.., Count 1 -> 0, no PathDone.
REQ-033 SHALL test: 8 back-to-back pushes with OutReady = 0 -> Count = 8, DRAMReadDataReady = 0; 9th push -> dropped, Overflow = 1 next cycle (macro on) / 0 (macro off).
REQ-034 SHALL test: full (Count 8) with simultaneous push and pop -> Count stays 8, no Overflow, order preserved.
REQ-035 SHALL test: 12 beats 1..12 streamed, OutReady toggled 1,0,1,0.. -> output order 1..12; PathDone pulses exactly on pops of beats 6 and 12.
REQ-036 SHALL test: Reset asserted after 3 of 6 beats pushed -> next cycle Count = 0, OutValid = 0; a following 6-beat path gives PathDone on its 6th pop.
REQ-037 SHALL test: 20 pushes with OutReady = 1 continuously -> pointers wrap twice with no loss; Count <= 1 throughout.

Source files
------------

// File: rtl/path_read_buffer_pkg.sv
// Shared ORAM geometry for the path read buffer: tree depth, bucket size, beat width.
// Derives beats per path and the buffer depth (next power of two that holds one path).
// Ports: none (package).
package path_read_buffer_pkg;

  localparam int ORAML      = 2;    // tree levels below the root
  localparam int ORAMZ      = 4;    // blocks per bucket
  localparam int BLOCK_BITS = 256;  // payload bits per block
  localparam int BED_WIDTH  = 512;  // DRAM read beat width

  localparam int BUCKET_BEATS = (ORAMZ * BLOCK_BITS) / BED_WIDTH;
  localparam int PATH_BEATS   = (ORAML + 1) * BUCKET_BEATS;

  // Smallest power of two >= n, so the pointers can wrap by simple overflow.
  function automatic int pow2_ceil(input int n);
    int p;
    p = 1;
    for (int i = 0; i < 31; i++) begin
      if (p < n) p = p * 2;
    end
    return p;
  endfunction

  localparam int PATH_DEPTH = pow2_ceil(PATH_BEATS);

endpackage

// File: rtl/PathBufferRAM.sv
// Storage for the path read buffer: Depth x Width, one write port, one registered read port.
// Latency: rd_data updates one cycle after rd_en; a same-cycle write to rd_addr is forwarded.
// Backpressure: none; the caller decides when to write and read.
// Ports: clk; wr_en/wr_addr/wr_data write port; rd_en/rd_addr read request; rd_data registered output.
module PathBufferRAM #(
  parameter int Width = 512,
  parameter int Depth = 8
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(Depth)-1:0] wr_addr,
  input  logic [Width-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(Depth)-1:0] rd_addr,
  output logic [Width-1:0]         rd_data
);

  logic [Width-1:0] mem [Depth];

  // Contents are never reset; only the pointers in the controller define validity.
  // Forwarding lets a beat written into an empty buffer appear at rd_data one
  // cycle later instead of two.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
  end

endmodule

// File: rtl/path_read_buffer.sv
// Buffers DRAM read beats of an ORAM path ahead of the AES/backend consumer, in arrival order.
// Latency: a beat pushed into an empty buffer is presented on OutData the next cycle.
// Backpressure: DRAM cannot stall; DRAMReadDataReady is advisory and a beat offered while it is low is dropped.
// Ports: Clock, Reset (sync, active high); DRAMReadData/DRAMReadDataValid/DRAMReadDataReady input beat;
//        OutData/OutValid/OutReady head beat; Count beats held; PathDone pulse the cycle after the
//        last pop of a path; Overflow sticky drop flag.
// Build option: define PBF_OVERFLOW_CHECK_EN to enable the sticky Overflow flag (tied low otherwise).
module path_read_buffer
  import path_read_buffer_pkg::*;
#(
  parameter int BEDWidth  = BED_WIDTH,
  parameter int Depth     = PATH_DEPTH,
  parameter int PathBeats = PATH_BEATS
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic [BEDWidth-1:0]        DRAMReadData,
  input  logic                       DRAMReadDataValid,
  output logic                       DRAMReadDataReady,
  output logic [BEDWidth-1:0]        OutData,
  output logic                       OutValid,
  input  logic                       OutReady,
  output logic [$clog2(Depth+1)-1:0] Count,
  output logic                       PathDone,
  output logic                       Overflow
);

  localparam int AW = $clog2(Depth);
  localparam int CW = $clog2(Depth + 1);
  localparam int PW = (PathBeats > 1) ? $clog2(PathBeats) : 1;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;   // next slot to load into the output register
  logic [PW-1:0] pop_cnt;
  logic          push;
  logic          pop;
  logic          staged;
  logic          load;

  // Count includes the head beat sitting in the RAM output register; that slot
  // stays occupied until popped, so a full buffer may accept a beat only while
  // the head leaves in the same cycle (the write lands in the head's old slot).
  assign pop               = OutValid && OutReady;
  assign DRAMReadDataReady = (Count < CW'(Depth)) || pop;
  assign push              = DRAMReadDataValid && DRAMReadDataReady && !Reset;

  // Beats stored behind the head. OutValid is high whenever Count is non-zero,
  // so this is simply Count > OutValid.
  assign staged = Count > CW'(OutValid);

  // Refill the output register when it is empty or being consumed, from the
  // RAM if something is staged, otherwise from the beat arriving now.
  assign load = (staged || push) && (!OutValid || pop);

  PathBufferRAM #(
    .Width (BEDWidth),
    .Depth (Depth)
  ) u_ram (
    .clk     (Clock),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (DRAMReadData),
    .rd_en   (load),
    .rd_addr (rd_ptr),
    .rd_data (OutData)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      Count    <= '0;
      OutValid <= 1'b0;
      pop_cnt  <= '0;
      PathDone <= 1'b0;
    end else begin
      PathDone <= 1'b0;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (load) rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      Count <= Count + CW'(1);
      else if (pop && !push) Count <= Count - CW'(1);
      if (load)     OutValid <= 1'b1;
      else if (pop) OutValid <= 1'b0;
      if (pop) begin
        if (pop_cnt == PW'(PathBeats - 1)) begin
          pop_cnt  <= '0;
          PathDone <= 1'b1;
        end else begin
          pop_cnt <= pop_cnt + PW'(1);
        end
      end
    end
  end

`ifdef PBF_OVERFLOW_CHECK_EN
  logic drop;
  assign drop = DRAMReadDataValid && !DRAMReadDataReady && !Reset;

  always_ff @(posedge Clock) begin
    if (Reset)     Overflow <= 1'b0;
    else if (drop) Overflow <= 1'b1;
  end

`ifdef SIMULATION
  always_ff @(posedge Clock) begin
    if (drop) begin
      $error("path_read_buffer: DRAM beat dropped, buffer full");
      $stop;
    end
  end
`endif
`else
  assign Overflow = 1'b0;
`endif

endmodule

// File: tb/tb_path_read_buffer.sv
// Self-checking bench for path_read_buffer against a queue-based reference model.
// Inputs change on the falling edge; outputs are compared on the falling edge.
// Ports: none (top-level bench).
module tb_path_read_buffer;

  localparam int W     = 512;
  localparam int DEPTH = 8;
  localparam int PB    = 6;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  din;
  logic          din_vld;
  logic          din_rdy;
  logic [W-1:0]  dout;
  logic          dout_vld;
  logic          dout_rdy;
  logic [CW-1:0] count;
  logic          path_done;
  logic          overflow;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: beats held in arrival order plus path pop position.
  logic [W-1:0] q[$];
  int           pops_in_path;
  logic         exp_done;
  logic         exp_ovf;

  // Observations from the most recent step.
  logic         st_pop;
  logic         st_rdy_exp;
  logic         st_rdy_dut;
  logic [W-1:0] st_pop_exp;
  logic [W-1:0] st_pop_dut;

  path_read_buffer #(
    .BEDWidth  (W),
    .Depth     (DEPTH),
    .PathBeats (PB)
  ) dut (
    .Clock             (clk),
    .Reset             (rst),
    .DRAMReadData      (din),
    .DRAMReadDataValid (din_vld),
    .DRAMReadDataReady (din_rdy),
    .OutData           (dout),
    .OutValid          (dout_vld),
    .OutReady          (dout_rdy),
    .Count             (count),
    .PathDone          (path_done),
    .Overflow          (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] rand_beat();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // One clock: drive inputs, predict handshake from the model, advance to the next falling edge.
  task automatic step(input logic v, input logic [W-1:0] d, input logic r);
    logic m_pop;
    logic m_rdy;
    din_vld  = v;
    din      = d;
    dout_rdy = r;
    m_pop = (q.size() > 0) && r;
    m_rdy = (q.size() < DEPTH) || m_pop;
    #1;
    st_pop     = m_pop;
    st_rdy_exp = m_rdy;
    st_rdy_dut = din_rdy;
    st_pop_dut = dout;
    st_pop_exp = '0;
    if (m_pop) st_pop_exp = q[0];
    @(posedge clk);
    exp_done = 1'b0;
    if (m_pop) begin
      void'(q.pop_front());
      if (pops_in_path == PB - 1) begin
        pops_in_path = 0;
        exp_done     = 1'b1;
      end else begin
        pops_in_path++;
      end
    end
    if (v && m_rdy) q.push_back(d);
`ifdef PBF_OVERFLOW_CHECK_EN
    if (v && !m_rdy) exp_ovf = 1'b1;
`endif
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    din_vld  = 1'b1;           // beats offered during reset must be ignored
    din      = rand_beat();
    dout_rdy = 1'($urandom_range(0, 1));
    @(posedge clk);
    @(negedge clk);
    rst      = 1'b0;
    din_vld  = 1'b0;
    dout_rdy = 1'b0;
    q.delete();
    pops_in_path = 0;
    exp_done     = 1'b0;
    exp_ovf      = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_tests++; if (count !== '0)      begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_tests++; if (dout_vld !== 1'b0) begin n_fail++; $display("FAIL reset_outvalid: got %b want 0", dout_vld); end
    n_tests++; if (path_done !== 1'b0) begin n_fail++; $display("FAIL reset_pathdone: got %b want 0", path_done); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    n_tests++; if (din_rdy !== 1'b1)  begin n_fail++; $display("FAIL reset_ready: got %b want 1", din_rdy); end
    @(negedge clk);
  endtask

  task automatic test_single_beat();
    logic [W-1:0] a5;
    a5 = {64{8'hA5}};
    do_reset();
    step(1'b1, a5, 1'b1);
    n_tests++; if (dout_vld !== 1'b1 || dout !== a5) begin n_fail++; $display("FAIL single_out: got vld=%b dat=%h want vld=1 dat=%h", dout_vld, dout, a5); end
    n_tests++; if (count !== CW'(1)) begin n_fail++; $display("FAIL single_count1: got %0d want 1", count); end
    step(1'b0, '0, 1'b1);
    n_tests++; if (!st_pop || st_pop_dut !== a5) begin n_fail++; $display("FAIL single_pop: got pop=%b dat=%h want dat=%h", st_pop, st_pop_dut, a5); end
    n_tests++; if (count !== '0 || dout_vld !== 1'b0) begin n_fail++; $display("FAIL single_empty: got count=%0d vld=%b want 0/0", count, dout_vld); end
    n_tests++; if (path_done !== 1'b0) begin n_fail++; $display("FAIL single_pathdone: got %b want 0", path_done); end
  endtask

  task automatic test_fill_overflow();
    logic [W-1:0] first;
    int guard;
    do_reset();
    first = rand_beat();
    step(1'b1, first, 1'b0);
    for (int i = 1; i < DEPTH; i++) step(1'b1, rand_beat(), 1'b0);
    n_tests++; if (count !== CW'(DEPTH)) begin n_fail++; $display("FAIL full_count: got %0d want %0d", count, DEPTH); end
    step(1'b1, rand_beat(), 1'b0);  // ninth beat: no room, must be dropped
    n_tests++; if (st_rdy_dut !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b want 0", st_rdy_dut); end
    n_tests++; if (count !== CW'(DEPTH) || dout !== first) begin n_fail++; $display("FAIL drop_intact: got count=%0d dat=%h want %0d dat=%h", count, dout, DEPTH, first); end
`ifdef PBF_OVERFLOW_CHECK_EN
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL drop_overflow: got %b want 1", overflow); end
`else
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL drop_overflow: got %b want 0", overflow); end
`endif
    guard = 0;
    while (q.size() > 0 && guard < 40) begin
      step(1'b0, '0, 1'b1);
      n_tests++; if (st_pop_dut !== st_pop_exp) begin n_fail++; $display("FAIL drop_drain_order: got %h want %h", st_pop_dut, st_pop_exp); end
      guard++;
    end
    n_tests++; if (count !== '0) begin n_fail++; $display("FAIL drop_drain_done: got count=%0d want 0", count); end
  endtask

  task automatic test_full_simultaneous();
    int guard;
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b1, rand_beat(), 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, rand_beat(), 1'b1);
      n_tests++; if (st_rdy_dut !== 1'b1) begin n_fail++; $display("FAIL fullsim_ready: got %b want 1", st_rdy_dut); end
      n_tests++; if (st_pop_dut !== st_pop_exp) begin n_fail++; $display("FAIL fullsim_order: got %h want %h", st_pop_dut, st_pop_exp); end
      n_tests++; if (count !== CW'(DEPTH) || overflow !== 1'b0) begin n_fail++; $display("FAIL fullsim_count: got count=%0d ovf=%b want %0d/0", count, overflow, DEPTH); end
    end
    guard = 0;
    while (q.size() > 0 && guard < 60) begin
      step(1'b0, '0, 1'($urandom_range(0, 1)));
      if (st_pop) begin
        n_tests++; if (st_pop_dut !== st_pop_exp) begin n_fail++; $display("FAIL fullsim_drain: got %h want %h", st_pop_dut, st_pop_exp); end
      end
      guard++;
    end
    n_tests++; if (q.size() != 0) begin n_fail++; $display("FAIL fullsim_timeout: got %0d beats left want 0", q.size()); end
  endtask

  task automatic test_path_stream();
    int next_in;
    int next_out;
    int pulses;
    logic r;
    do_reset();
    next_in  = 1;
    next_out = 1;
    pulses   = 0;
    r        = 1'b1;
    for (int cyc = 0; cyc < 80 && next_out <= 12; cyc++) begin
      step(next_in <= 12, W'(next_in), r);
      if (next_in <= 12 && st_rdy_exp) next_in++;
      if (st_pop) begin
        n_tests++; if (st_pop_dut !== W'(next_out)) begin n_fail++; $display("FAIL stream_order: got %0d want %0d", st_pop_dut, next_out); end
        n_tests++; if (path_done !== (next_out % PB == 0)) begin n_fail++; $display("FAIL stream_pathdone: beat %0d got %b want %b", next_out, path_done, next_out % PB == 0); end
        next_out++;
      end else begin
        n_tests++; if (path_done !== 1'b0) begin n_fail++; $display("FAIL stream_idle_pathdone: got %b want 0", path_done); end
      end
      if (path_done === 1'b1) pulses++;
      r = ~r;
    end
    n_tests++; if (next_out != 13 || pulses != 2) begin n_fail++; $display("FAIL stream_totals: got %0d beats %0d pulses want 12/2", next_out - 1, pulses); end
  endtask

  task automatic test_reset_midpath();
    int pops;
    int sent;
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, W'(100 + i), 1'b0);
    n_tests++; if (count !== CW'(3)) begin n_fail++; $display("FAIL midpath_count3: got %0d want 3", count); end
    do_reset();
    n_tests++; if (count !== '0 || dout_vld !== 1'b0) begin n_fail++; $display("FAIL midpath_cleared: got count=%0d vld=%b want 0/0", count, dout_vld); end
    pops = 0;
    sent = 0;
    for (int cyc = 0; cyc < 40 && pops < PB; cyc++) begin
      step(sent < PB, W'(200 + sent), 1'($urandom_range(0, 3) != 0));
      if (sent < PB && st_rdy_exp) sent++;
      if (st_pop) begin
        pops++;
        n_tests++; if (st_pop_dut !== st_pop_exp) begin n_fail++; $display("FAIL midpath_order: got %h want %h", st_pop_dut, st_pop_exp); end
        n_tests++; if (path_done !== (pops == PB)) begin n_fail++; $display("FAIL midpath_pathdone: pop %0d got %b want %b", pops, path_done, pops == PB); end
      end
    end
    n_tests++; if (pops != PB) begin n_fail++; $display("FAIL midpath_timeout: got %0d pops want %0d", pops, PB); end
  endtask

  task automatic test_wrap();
    int pops;
    do_reset();
    pops = 0;
    for (int i = 0; i < 22; i++) begin
      step(i < 20, rand_beat(), 1'b1);
      n_tests++; if (count > CW'(1)) begin n_fail++; $display("FAIL wrap_count: got %0d want <=1", count); end
      if (st_pop) begin
        pops++;
        n_tests++; if (st_pop_dut !== st_pop_exp) begin n_fail++; $display("FAIL wrap_order: got %h want %h", st_pop_dut, st_pop_exp); end
      end
    end
    n_tests++; if (pops != 20) begin n_fail++; $display("FAIL wrap_total: got %0d pops want 20", pops); end
  endtask

  task automatic test_random();
    int rdy_pct;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rdy_pct = (i % 100 < 40) ? 20 : 70;   // alternate slow and fast consumer phases
      step(1'($urandom_range(0, 99) < 70), rand_beat(), 1'($urandom_range(0, 99) < rdy_pct));
      n_tests++; if (st_rdy_dut !== st_rdy_exp) begin n_fail++; $display("FAIL rand_ready: cyc %0d got %b want %b", i, st_rdy_dut, st_rdy_exp); end
      if (st_pop) begin
        n_tests++; if (st_pop_dut !== st_pop_exp) begin n_fail++; $display("FAIL rand_pop: cyc %0d got %h want %h", i, st_pop_dut, st_pop_exp); end
      end
      n_tests++; if (count !== CW'(q.size()) || dout_vld !== (q.size() > 0)) begin n_fail++; $display("FAIL rand_state: cyc %0d got count=%0d vld=%b want %0d/%b", i, count, dout_vld, q.size(), q.size() > 0); end
      if (q.size() > 0) begin
        n_tests++; if (dout !== q[0]) begin n_fail++; $display("FAIL rand_head: cyc %0d got %h want %h", i, dout, q[0]); end
      end
      n_tests++; if (path_done !== exp_done || overflow !== exp_ovf) begin n_fail++; $display("FAIL rand_flags: cyc %0d got done=%b ovf=%b want %b/%b", i, path_done, overflow, exp_done, exp_ovf); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    din      = '0;
    din_vld  = 1'b0;
    dout_rdy = 1'b0;
    exp_done = 1'b0;
    exp_ovf  = 1'b0;
    pops_in_path = 0;
    test_reset();
    test_single_beat();
    test_fill_overflow();
    test_full_simultaneous();
    test_path_stream();
    test_reset_midpath();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
